// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-register chain.
package pipe_pkg;

    // Input buffering mode of the chain.
    typedef enum logic {
        SKID_NONE = 1'b0,   // combinational ready path straight through the stages
        SKID_ONE  = 1'b1    // one-entry skid buffer, registered ready
    } skid_mode_e;

    // All-ones ceiling for the drop counter; sliced to the counter width by the user.
    localparam logic [63:0] DROP_SAT = '1;

    // Bits needed to count every live beat: the skid entry plus all stages.
    function automatic int OCC_W(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: a valid bit and its payload, with load and kill.
module pipe_stage_reg #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,        // stage takes the upstream beat this edge
    input  logic             i_ld_valid,   // upstream beat is live (already flush-qualified)
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic             i_kill,       // kill the beat currently held here
    output logic             o_valid,      // registered valid
    output logic             o_valid_eff,  // valid after this cycle's kill
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_valid     = r_valid;
    assign o_valid_eff = r_valid & ~i_kill;
    assign o_data      = r_data;

    // Load on advance (payload only when the incoming beat is live), else hold minus kill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_ld_valid;
            if (i_ld_valid) begin
                r_data <= i_ld_data;
            end
        end else begin
            r_valid <= r_valid & ~i_kill;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Elastic valid/ready register chain with per-stage flush, global hold,
// optional input skid buffer and occupancy / drop telemetry.
module pipe_chain import pipe_pkg::*; #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [WIDTH-1:0]             i_in_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [WIDTH-1:0]             o_out_data,
    input  logic                         i_hold,
    input  logic [STAGES-1:0]            i_flush,
    input  logic                         i_flush_in,
    output logic [OCC_W(STAGES)-1:0]     o_occupancy,
    output logic [CNT_W-1:0]             o_drop_cnt
);

    localparam int OW     = OCC_W(STAGES);
    // Kills per cycle: every stage, the skid entry and the incoming beat.
    localparam int KILL_W = $clog2(STAGES + 3);
    localparam int SUM_W  = CNT_W + KILL_W;
    localparam logic [CNT_W-1:0] CNT_SAT = DROP_SAT[CNT_W-1:0];

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_ve;
    logic [STAGES-1:0] w_ld_v;
    logic [WIDTH-1:0]  w_ld_d [STAGES];
    logic [WIDTH-1:0]  w_d    [STAGES];

    logic              w_src_v;    // beat offered to stage 0
    logic [WIDTH-1:0]  w_src_d;
    logic              w_skid_v;
    logic              w_in_kill;  // upstream handshake completed but killed by FLUSH_IN
    logic [KILL_W-1:0] w_kills;
    logic [OW-1:0]     w_occ;
    logic [SUM_W-1:0]  w_drop_sum;
    logic [CNT_W-1:0]  r_drop_cnt;

    // Advance chain, evaluated from the output back towards the input.
    always_comb begin
        logic w_down;
        w_down = i_out_ready;
        w_adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_down   = ~i_hold & (~w_ve[k] | w_down);
            w_adv[k] = w_down;
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_ld_v[gi] = w_src_v;
                assign w_ld_d[gi] = w_src_d;
            end else begin : g_body
                // A beat flushed this cycle travels on as a bubble.
                assign w_ld_v[gi] = w_ve[gi-1];
                assign w_ld_d[gi] = w_d[gi-1];
            end

            pipe_stage_reg #(
                .WIDTH (WIDTH)
            ) u_stage (
                .i_clk       (i_clk),
                .i_rst_n     (i_rst_n),
                .i_adv       (w_adv[gi]),
                .i_ld_valid  (w_ld_v[gi]),
                .i_ld_data   (w_ld_d[gi]),
                .i_kill      (i_flush[gi]),
                .o_valid     (w_v[gi]),
                .o_valid_eff (w_ve[gi]),
                .o_data      (w_d[gi])
            );
        end

        if (SKID == int'(SKID_ONE)) begin : g_skid
            logic             r_skid_v;
            logic [WIDTH-1:0] r_skid_d;
            logic             w_accept;

            // Ready comes straight from a flop, cutting the downstream ready path.
            assign o_in_ready = ~r_skid_v;
            assign w_accept   = i_in_valid & ~r_skid_v & ~i_flush_in;
            assign w_in_kill  = i_in_valid & ~r_skid_v & i_flush_in;
            assign w_skid_v   = r_skid_v;
            // The skid always drains ahead of new input, keeping FIFO order.
            assign w_src_v    = r_skid_v ? ~i_flush_in : w_accept;
            assign w_src_d    = r_skid_v ? r_skid_d : i_in_data;

            // Skid entry: cleared by FLUSH_IN or drain, filled when stage 0 cannot take the beat.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_skid_v <= 1'b0;
                    r_skid_d <= '0;
                end else if (i_flush_in) begin
                    r_skid_v <= 1'b0;
                end else if (r_skid_v) begin
                    if (w_adv[0]) begin
                        r_skid_v <= 1'b0;
                    end
                end else if (w_accept && !w_adv[0]) begin
                    r_skid_v <= 1'b1;
                    r_skid_d <= i_in_data;
                end
            end
        end else begin : g_noskid
            assign o_in_ready = w_adv[0];
            assign w_in_kill  = i_in_valid & w_adv[0] & i_flush_in;
            assign w_skid_v   = 1'b0;
            assign w_src_v    = i_in_valid & w_adv[0] & ~i_flush_in;
            assign w_src_d    = i_in_data;
        end
    endgenerate

    // Live beats killed this cycle and live beats held, both from registered state.
    always_comb begin
        w_kills = KILL_W'(w_skid_v & i_flush_in) + KILL_W'(w_in_kill);
        w_occ   = OW'(w_skid_v);
        for (int k = 0; k < STAGES; k++) begin
            w_kills = w_kills + KILL_W'(w_v[k] & i_flush[k]);
            w_occ   = w_occ + OW'(w_v[k]);
        end
    end

    assign w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_kills);

    // Saturating drop counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum > SUM_W'(CNT_SAT)) begin
            r_drop_cnt <= CNT_SAT;
        end else begin
            r_drop_cnt <= w_drop_sum[CNT_W-1:0];
        end
    end

    assign o_out_valid = w_ve[STAGES-1] & ~i_hold;
    assign o_out_data  = w_d[STAGES-1];
    assign o_occupancy = w_occ;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: a slot-list model for the default
// build plus directed checks on a SKID=0 build and a CNT_W=2 build.
module tb_pipe_chain;

    localparam int S = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Default build: STAGES=4, SKID=1, CNT_W=16
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_hold, a_flush_in;
    logic [W-1:0] a_in_data, a_out_data;
    logic [S-1:0] a_flush;
    logic [2:0]   a_occ;
    logic [15:0]  a_drop;
    // SKID=0 build
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hold, b_flush_in;
    logic [W-1:0] b_in_data, b_out_data;
    logic [S-1:0] b_flush;
    logic [2:0]   b_occ;
    logic [15:0]  b_drop;
    // CNT_W=2 build
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_hold, c_flush_in;
    logic [W-1:0] c_in_data, c_out_data;
    logic [S-1:0] c_flush;
    logic [2:0]   c_occ;
    logic [1:0]   c_drop;

    pipe_chain #(.WIDTH(W), .STAGES(S), .SKID(1), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
        .i_in_data(a_in_data), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
        .o_out_data(a_out_data), .i_hold(a_hold), .i_flush(a_flush), .i_flush_in(a_flush_in),
        .o_occupancy(a_occ), .o_drop_cnt(a_drop));

    pipe_chain #(.WIDTH(W), .STAGES(S), .SKID(0), .CNT_W(16)) dut_noskid (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
        .i_in_data(b_in_data), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
        .o_out_data(b_out_data), .i_hold(b_hold), .i_flush(b_flush), .i_flush_in(b_flush_in),
        .o_occupancy(b_occ), .o_drop_cnt(b_drop));

    pipe_chain #(.WIDTH(W), .STAGES(S), .SKID(1), .CNT_W(2)) dut_cnt2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(c_in_valid), .o_in_ready(c_in_ready),
        .i_in_data(c_in_data), .o_out_valid(c_out_valid), .i_out_ready(c_out_ready),
        .o_out_data(c_out_data), .i_hold(c_hold), .i_flush(c_flush), .i_flush_in(c_flush_in),
        .o_occupancy(c_occ), .o_drop_cnt(c_drop));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Beats seen leaving the default build, and the expected order for a test.
    logic [31:0] delivered[$];
    logic [31:0] exp_q[$];
    int          peak_occ;

    task automatic chk_seq(input string name);
        chk({name, "_count"}, delivered.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            chk({name, "_beat"}, (j < delivered.size()) ? delivered[j] : 32'hDEAD_BEEF, exp_q[j]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of the default build: a list of slots (stage 0 .. S-1) plus a skid entry.
    // Each cycle: remove flushed beats, pop the output on a handshake, then every beat
    // below the highest empty slot moves forward one place and slot 0 takes the
    // skid entry (first) or the new input. An input that finds no room waits in the skid.
    logic        m_v [S];
    logic [31:0] m_d [S];
    logic        m_sv;
    logic [31:0] m_sd;
    int          m_drop;

    initial begin : model
        int   hole;
        logic acc;
        logic rdy;
        for (int k = 0; k < S; k++) begin m_v[k] = 1'b0; m_d[k] = '0; end
        m_sv = 1'b0; m_sd = '0; m_drop = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < S; k++) m_v[k] = 1'b0;
                m_sv   = 1'b0;
                m_drop = 0;
            end else begin
                rdy = !m_sv;
                for (int k = 0; k < S; k++) begin
                    if (m_v[k] && a_flush[k]) begin m_v[k] = 1'b0; m_drop++; end
                end
                if (m_sv && a_flush_in) begin m_sv = 1'b0; m_drop++; end
                if (a_in_valid && rdy && a_flush_in) m_drop++;
                acc = a_in_valid && rdy && !a_flush_in;
                if (!a_hold) begin
                    if (m_v[S-1] && a_out_ready) m_v[S-1] = 1'b0;
                    hole = -1;
                    for (int k = 0; k < S; k++) if (!m_v[k]) hole = k;
                    if (hole >= 0) begin
                        for (int k = hole; k > 0; k--) begin
                            m_v[k] = m_v[k-1];
                            m_d[k] = m_d[k-1];
                        end
                        if (m_sv) begin
                            m_v[0] = 1'b1; m_d[0] = m_sd; m_sv = 1'b0;
                        end else if (acc) begin
                            m_v[0] = 1'b1; m_d[0] = a_in_data; acc = 1'b0;
                        end else begin
                            m_v[0] = 1'b0;
                        end
                    end
                end
                if (acc) begin m_sv = 1'b1; m_sd = a_in_data; end
            end
        end
    end

    // Compare the default build against the model mid-cycle, every cycle out of reset.
    logic m_en = 1'b0;
    initial begin : compare
        int   occ;
        logic ov;
        forever begin
            @(negedge clk);
            if (rst_n && m_en) begin
                ov  = m_v[S-1] && !a_flush[S-1] && !a_hold;
                occ = int'(m_sv);
                for (int k = 0; k < S; k++) occ += int'(m_v[k]);
                chk("out_valid", a_out_valid, ov);
                if (ov) chk("out_data", a_out_data, m_d[S-1]);
                chk("in_ready", a_in_ready, !m_sv);
                chk("occupancy", a_occ, occ);
                chk("drop_cnt", a_drop, m_drop);
                if (a_out_valid && a_out_ready) delivered.push_back(a_out_data);
                if (int'(a_occ) > peak_occ) peak_occ = int'(a_occ);
            end
        end
    end

    initial begin : stim
        int   n;
        int   sent;
        logic rdy;
        rst_n = 1'b0;
        {a_in_valid, a_out_ready, a_hold, a_flush_in} = '0; a_in_data = '0; a_flush = '0;
        {b_in_valid, b_out_ready, b_hold, b_flush_in} = '0; b_in_data = '0; b_flush = '0;
        {c_in_valid, c_out_ready, c_hold, c_flush_in} = '0; c_in_data = '0; c_flush = '0;
        peak_occ = 0;

        // Reset state
        #2;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_occ", a_occ, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_drop", a_drop, 0);
        chk("rst_noskid_ready", b_in_ready, 1);
        b_hold = 1'b1; #1;
        chk("rst_noskid_ready_hold", b_in_ready, 0);
        b_hold = 1'b0;
        step();
        rst_n = 1'b1;
        m_en  = 1'b1;

        // 1: stream 1..8 with OUT_READY high
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1; a_in_data = i;
            step();
            chk("t1_latency_valid", a_out_valid, (i >= 4));
        end
        a_in_valid = 1'b0;
        repeat (8) step();
        chk("t1_peak_occ", peak_occ, 4);
        exp_q = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        chk_seq("t1_stream");

        // 2: fill with OUT_READY low, then drain
        delivered.delete();
        a_out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1; a_in_data = n + 1;
            rdy = a_in_ready;
            step();
            if (rdy) n++;
        end
        chk("t2_accepts", n, 5);
        chk("t2_occ_full", a_occ, 5);
        chk("t2_ready_low", a_in_ready, 0);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (8) step();
        exp_q = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        chk_seq("t2_drain");

        // 3: chain D,C,B,A (D at output), flush stages 1 and 2
        delivered.delete();
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'hD - i;
            step();
        end
        a_in_valid = 1'b0;
        chk("t3_occ_full", a_occ, 4);
        a_flush = 4'b0110;
        step();
        a_flush = '0;
        chk("t3_drop", a_drop, 2);
        chk("t3_occ_after", a_occ, 2);
        a_out_ready = 1'b1;
        repeat (6) step();
        exp_q = {32'hD, 32'hA};
        chk_seq("t3_flush");

        // 4: HOLD for 3 cycles while streaming, FLUSH[0] in the middle of it
        delivered.delete();
        sent = 0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            a_hold     = (c >= 4 && c < 7);
            a_flush    = (c == 5) ? 4'b0001 : 4'b0000;
            a_in_valid = (sent < 10);
            a_in_data  = 32'h21 + sent;
            if (a_hold) begin
                #1;
                chk("t4_hold_valid", a_out_valid, 0);
                chk("t4_hold_data", a_out_data, 32'h21);
            end
            rdy = a_in_ready;
            step();
            if (rdy && a_in_valid) sent++;
            if (c == 5) chk("t4_drop", a_drop, 3);
        end
        a_hold = 1'b0; a_flush = '0; a_in_valid = 1'b0;
        exp_q = {32'h21, 32'h22, 32'h23, 32'h25, 32'h26, 32'h27, 32'h28, 32'h29, 32'h2A};
        chk_seq("t4_hold");

        // 5: SKID=0 build, combinational ready
        b_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1; b_in_data = 32'h51 + i;
            #1;
            chk("t5_ready_fill", b_in_ready, 1);
            step();
        end
        b_in_data = 32'h55;
        #1;
        chk("t5_ready_full", b_in_ready, 0);
        chk("t5_occ_full", b_occ, 4);
        b_out_ready = 1'b1;
        #1;
        chk("t5_ready_same_cycle", b_in_ready, 1);
        chk("t5_out_valid", b_out_valid, 1);
        chk("t5_out_data", b_out_data, 32'h51);
        step();
        b_in_valid = 1'b0;
        chk("t5_occ_after", b_occ, 4);
        for (int j = 0; j < 4; j++) begin
            chk("t5_drain_valid", b_out_valid, 1);
            chk("t5_drain_data", b_out_data, 32'h52 + j);
            step();
        end
        chk("t5_empty", b_out_valid, 0);
        chk("t5_no_drop", b_drop, 0);
        b_hold = 1'b1;
        #1;
        chk("t5_hold_ready", b_in_ready, 0);
        b_hold = 1'b0;

        // 6: CNT_W=2 saturation, then asynchronous reset mid-stream
        c_in_valid = 1'b1; c_flush_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            c_in_data = i;
            step();
            chk("t6_drop_sat", c_drop, (i < 3) ? i : 3);
        end
        c_flush_in = 1'b0;
        c_out_ready = 1'b1; c_in_data = 32'h61;
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h71;
        step();
        step();
        chk("t6_occ_busy", c_occ, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", c_out_valid, 0);
        chk("t6_rst_data", c_out_data, 0);
        chk("t6_rst_occ", c_occ, 0);
        chk("t6_rst_drop", c_drop, 0);
        chk("t6_rst_ready", c_in_ready, 1);
        chk("t6_rst_main_occ", a_occ, 0);
        chk("t6_rst_main_data", a_out_data, 0);
        chk("t6_rst_main_drop", a_drop, 0);
        a_in_valid = 1'b0; c_in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
Parametrised elastic pipeline-register chain. It replaces the CPU's fixed, ad-hoc stage-register updates, which rely on global busy-wait freeze and a single flush, with a proper valid/ready handshake. Features: per-stage flush, global hold (cache busy-wait), an optional input skid buffer that cuts the ready path, and occupancy/drop telemetry. It is instantiated between the fetch and memory stages of the next-generation RV32IM pipeline and in the data-cache request path.

Parameters:
WIDTH, 32, payload bits per stage
STAGES, 4, number of register stages (>=1)
SKID, 1, 1 = registered IN_READY via 1-entry input skid buffer; 0 = combinational IN_READY
CNT_W, 16, width of DROP_CNT (saturating)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  reset, asynchronous, active-low
IN_VALID  in  1  upstream beat valid
IN_READY  out  1  chain can accept
IN_DATA  in  WIDTH  upstream payload
OUT_VALID  out  1  stage STAGES-1 holds a live beat
OUT_READY  in  1  downstream accepts
OUT_DATA  out  WIDTH  payload of stage STAGES-1
HOLD  in  1  global freeze (cache busy-wait)
FLUSH  in  STAGES  bit k kills the beat in stage k this cycle
FLUSH_IN  in  1  kills the skid entry and any beat accepted this cycle
OCCUPANCY  out  $clog2(STAGES+2)  live beats in skid + stages
DROP_CNT  out  CNT_W  saturating count of killed live beats

Behaviour:
- Reset state (RESET low, asynchronous): all stage valids 0, stage data 0, skid empty, DROP_CNT 0. Resulting outputs: OUT_VALID 0, OUT_DATA 0, OCCUPANCY 0, IN_READY 1 if SKID=1, and IN_READY = !HOLD if SKID=0.
- Effective valid: ve[k] = v[k] & !FLUSH[k].
- Advance enable: adv[STAGES] = OUT_READY; adv[k] = !HOLD & (!ve[k] | adv[k+1]).
- Stage update at each edge:
  - If adv[k], stage k loads ve[k-1]/d[k-1]. Stage 0 loads from the input source.
  - Else v[k] <= ve[k] and the data is held.
  - A flushed stage therefore empties even under HOLD.
- Output:
  - OUT_VALID = ve[STAGES-1] & !HOLD.
  - OUT_DATA = d[STAGES-1].
  - Transfer occurs when OUT_VALID & OUT_READY.
  - While OUT_VALID is high and OUT_READY is low, OUT_DATA is stable.
- SKID=0:
  - IN_READY = adv[0].
  - Accept = IN_VALID & IN_READY & !FLUSH_IN.
  - The accepted beat enters stage 0.
- SKID=1:
  - IN_READY = !skid_v (registered).
  - Input source for stage 0 is the skid entry if skid_v, otherwise IN_DATA (bypass).
  - If a beat is accepted while adv[0]=0, or while skid_v is already draining, it is stored in the skid.
  - The skid drains into stage 0 when adv[0].
  - FLUSH_IN clears skid_v and blocks the current accept.
  - Ordering is strict FIFO: the skid always drains before any new input.
- Latency: a beat accepted at edge t into an empty, unheld chain is in stage 0 after t. OUT_VALID rises after edge t+STAGES-1. Throughput is 1 beat/cycle with no bubbles when OUT_READY is held high.
- HOLD:
  - No stage advances, no input is accepted, and the output handshake is suppressed.
  - FLUSH still takes effect.
  - With SKID=1, IN_READY may stay high, but an accept under HOLD lands in the skid only if the skid is empty.
- Simultaneous FLUSH[k] and adv[k+1]: the killed beat does not propagate; stage k+1 loads invalid.
- DROP_CNT:
  - Increments by popcount of killed live beats per cycle (v[k]&FLUSH[k], plus skid_v&FLUSH_IN, plus accepted-but-flushed input).
  - Saturates at 2^CNT_W-1 and never wraps.
- OCCUPANCY = skid_v + sum(v[k]), from registered state.
- RESET asserted mid-transfer: all state is discarded immediately. A beat in flight is not counted as dropped.

Decomposition:
- Shared package pipe_pkg: OCC_W function (clog2 helper), DROP_SAT constant, and an enum for the SKID mode (SKID_NONE, SKID_ONE).
- Natural sub-module: pipe_stage_reg holds one stage (valid, data, load/kill). The chain is a generate loop over STAGES plus skid logic, the adv chain and counters.

Test Plan:
1. Reset with STAGES=4, SKID=1; stream 0x1..0x8 with OUT_READY=1 → first OUT_VALID 3 edges after the first accept; outputs 0x1..0x8 back-to-back; OCCUPANCY peaks at 4.
2. Fill the chain with OUT_READY=0 → IN_READY drops after 5 accepts (4 stages + skid) and OCCUPANCY=5; raise OUT_READY → 0x1..0x5 delivered in order, no loss.
3. Full chain holding A,B,C,D (D at output); pulse FLUSH=4'b0110 for one cycle → B,C removed, DROP_CNT=2; output sequence is D,A.
4. HOLD=1 for 3 cycles with the chain streaming → OUT_VALID=0 and all stage data frozen; FLUSH[0] during HOLD still clears stage 0 and DROP_CNT+1; on release, streaming resumes with no duplicated beats.
5. SKID=0 build: OUT_READY=0, full chain → IN_READY=0 combinationally; raise OUT_READY → IN_READY=1 in the same cycle and an accept occurs at that edge.
6. CNT_W=2: kill 5 beats → DROP_CNT saturates at 3. Assert RESET low mid-stream → all outputs zero asynchronously, before the next CLK edge.
